// File: rtl/key_pkg.sv
// Shared types and helpers for the key event controller.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } key_state_e;

  localparam logic KEY_ACTIVE = 1'b0;

  function automatic int cyc_per_ms(input int clk_cyc);
    return 1_000_000 / clk_cyc;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_ms_tick.sv
// Millisecond timebase: free-running cycle counter with synchronous clear.
module key_ms_tick #(
  parameter int CYC_PER_MS = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic ms_tick
);

  localparam int W = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [W-1:0] LAST = W'(CYC_PER_MS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign ms_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || ms_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns a debounced active-low key level into short/long/double-click pulses.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a long press is held.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int CLK_CYC   = 10,
  parameter int LONG_MS   = 1000,
  parameter int DCLK_MS   = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic sysclk,
  input  logic rst,
  input  logic en,
  input  logic key_in,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic busy
);

`ifdef KEY_REPEAT_EN
  localparam int MAX_MS = max_of(max_of(LONG_MS, DCLK_MS), REPEAT_MS);
`else
  localparam int MAX_MS = max_of(LONG_MS, DCLK_MS);
`endif
  localparam int W = $clog2(MAX_MS + 1);
  localparam logic [W-1:0] LONG_T = W'(LONG_MS);
  localparam logic [W-1:0] DCLK_T = W'(DCLK_MS);
  localparam logic [W-1:0] SAT    = '1;

  if (LONG_MS < 1 || DCLK_MS < 1 || REPEAT_MS < 1 ||
      (1_000_000 % CLK_CYC) != 0) begin : g_bad_cfg
    $error("key_event_ctrl: invalid timing parameters");
  end

  key_state_e state_q, state_d;
  logic [W-1:0] ms_cnt_q, ms_cnt_d;
  logic key_s_q, key_d_q;
  logic short_q, short_d;
  logic long_q, long_d;
  logic dbl_q, dbl_d;
  logic rep_clr, clr, ms_tick;
  logic prs_e, rel_e;

  // Input is registered once more so edge pulses land two cycles after key_in.
  assign prs_e = (key_d_q != KEY_ACTIVE) && (key_s_q == KEY_ACTIVE);
  assign rel_e = (key_d_q == KEY_ACTIVE) && (key_s_q != KEY_ACTIVE);

  key_ms_tick #(
    .CYC_PER_MS(cyc_per_ms(CLK_CYC))
  ) u_tick (
    .clk    (sysclk),
    .rst    (rst),
    .clr    (clr),
    .ms_tick(ms_tick)
  );

`ifdef KEY_REPEAT_EN
  localparam logic [W-1:0] REP_T = W'(REPEAT_MS);
  logic rep_q, rep_d;
  assign key_repeat = rep_q;
`else
  assign key_repeat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_clr = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = 1'b0;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: if (prs_e) state_d = PRESS1;
        PRESS1: begin
          if (rel_e) state_d = WAIT2;
          else if (ms_cnt_q == LONG_T) begin
            state_d = LONG;
            long_d  = 1'b1;
          end
        end
        WAIT2: begin
          if (prs_e) state_d = PRESS2;
          else if (ms_cnt_q == DCLK_T) begin
            state_d = IDLE;
            short_d = 1'b1;
          end
        end
        PRESS2: begin
          if (rel_e) begin
            state_d = IDLE;
            dbl_d   = 1'b1;
          end else if (ms_cnt_q == LONG_T) begin
            state_d = LONG;
            short_d = 1'b1;
            long_d  = 1'b1;
          end
        end
        LONG: begin
          if (rel_e) state_d = IDLE;
`ifdef KEY_REPEAT_EN
          else if (ms_cnt_q == REP_T) begin
            rep_d   = 1'b1;
            rep_clr = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  // Intervals are measured from state entry, so any transition restarts time.
  assign clr = !en || (state_d != state_q) || rep_clr;

  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if (clr) ms_cnt_d = '0;
    else if (ms_tick && ms_cnt_q != SAT) ms_cnt_d = ms_cnt_q + 1'b1;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ms_cnt_q <= '0;
      key_s_q  <= KEY_ACTIVE;
      key_d_q  <= KEY_ACTIVE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dbl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
      key_s_q  <= key_in;
      key_d_q  <= key_s_q;
      short_q  <= short_d;
      long_q   <= long_d;
      dbl_q    <= dbl_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) rep_q <= 1'b0;
    else     rep_q <= rep_d;
  end
`endif

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: vector table, corner sequences,
// and random key waveforms against a segment-level timing model.
module tb_key_event_ctrl;

  localparam int CLK_CYC   = 10_000;
  localparam int LONG_MS   = 2;
  localparam int DCLK_MS   = 1;
  localparam int REPEAT_MS = 1;
  localparam int N  = 1_000_000 / CLK_CYC;
  localparam int LT = LONG_MS * N;
  localparam int DT = DCLK_MS * N;
  localparam int RT = REPEAT_MS * N;
  localparam int FLUSH = LT + DT + RT + 20;

  logic sysclk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic key_in = 1'b1;
  logic short_press, long_press, double_click, key_repeat, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ev_q[$];

  key_event_ctrl #(
    .CLK_CYC  (CLK_CYC),
    .LONG_MS  (LONG_MS),
    .DCLK_MS  (DCLK_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .en          (en),
    .key_in      (key_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .key_repeat  (key_repeat),
    .busy        (busy)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Events encoded as cycle*4 + kind (0 short, 1 long, 2 double, 3 repeat).
  always @(negedge sysclk) begin
    if (short_press)  ev_q.push_back(cyc * 4 + 0);
    if (long_press)   ev_q.push_back(cyc * 4 + 1);
    if (double_click) ev_q.push_back(cyc * 4 + 2);
    if (key_repeat)   ev_q.push_back(cyc * 4 + 3);
  end

  typedef struct {
    int h1;
    int g;
    int h2;
    int n_s;
    int n_l;
    int n_d;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, " short"}, int'(short_press), 0);
    check({nm, " long"}, int'(long_press), 0);
    check({nm, " dbl"}, int'(double_click), 0);
    check({nm, " rep"}, int'(key_repeat), 0);
    check({nm, " busy"}, int'(busy), 0);
  endtask

  task automatic check_events(input string nm, input int exp[$]);
    check({nm, " event count"}, ev_q.size(), exp.size());
    foreach (exp[i])
      if (i < ev_q.size()) check({nm, " event (cyc*4+kind)"}, ev_q[i], exp[i]);
    ev_q.delete();
  endtask

  function automatic int count_kind(input int k);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i] % 4 == k) n++;
    return n;
  endfunction

  // segs alternates low/high durations, starting low; key_in is high before.
  task automatic run_segs(input int segs[$], output int a0);
    a0 = cyc;
    foreach (segs[i]) begin
      key_in = (i % 2 == 1);
      step(segs[i]);
    end
  endtask

  // Press edge at cycle a is seen at a+1 and the state is entered at a+2;
  // a hold of h cycles qualifies as long when h-1 > LT, a release gap g
  // counts as a second press when g-1 <= DT.
  task automatic model(input int a0, input int segs[$], output int exp[$]);
    int t, a, b, h, lastrel, e, r;
    bit pend;
    exp.delete();
    t = a0;
    pend = 0;
    lastrel = 0;
    for (int i = 0; i < segs.size(); i += 2) begin
      a = t;
      h = segs[i];
      b = a + h;
      t = b + segs[i+1];
      e = -1;
      if (pend && (a - lastrel - 1 <= DT)) begin
        pend = 0;
        if (h - 1 > LT) begin
          e = a + 2 + LT + 1;
          exp.push_back(e * 4 + 0);
          exp.push_back(e * 4 + 1);
        end else begin
          exp.push_back((b + 2) * 4 + 2);
        end
      end else begin
        if (pend) exp.push_back((lastrel + 2 + DT + 1) * 4 + 0);
        pend = 0;
        if (h - 1 > LT) begin
          e = a + 2 + LT + 1;
          exp.push_back(e * 4 + 1);
        end else begin
          pend = 1;
          lastrel = b;
        end
      end
`ifdef KEY_REPEAT_EN
      if (e >= 0) begin
        r = e + RT + 1;
        while (r <= b + 1) begin
          exp.push_back(r * 4 + 3);
          r += RT + 1;
        end
      end
`endif
    end
    if (pend) exp.push_back((lastrel + 2 + DT + 1) * 4 + 0);
  endtask

  function automatic int pick_len(input int th);
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(1, 20));
      1:       return th + int'($urandom_range(0, 3));
      default: return int'($urandom_range(1, th + 60));
    endcase
  endfunction

  vec_t vecs[9];
  int segs[$];
  int exp[$];
  int none[$];
  int a0, e, b;

  initial begin
    vecs[0] = '{50, 0, 0, 1, 0, 0};
    vecs[1] = '{300, 0, 0, 0, 1, 0};
    vecs[2] = '{201, 0, 0, 1, 0, 0};
    vecs[3] = '{202, 0, 0, 0, 1, 0};
    vecs[4] = '{30, 40, 30, 0, 0, 1};
    vecs[5] = '{30, 101, 30, 0, 0, 1};
    vecs[6] = '{30, 102, 30, 2, 0, 0};
    vecs[7] = '{30, 40, 300, 1, 1, 0};
    vecs[8] = '{1, 1, 1, 0, 0, 1};

    step(3);
    check_idle("reset");
    rst = 1'b0;
    en = 1'b1;
    step(5);
    check_idle("post reset idle");
    ev_q.delete();

    foreach (vecs[i]) begin
      segs.delete();
      segs.push_back(vecs[i].h1);
      if (vecs[i].h2 != 0) begin
        segs.push_back(vecs[i].g);
        segs.push_back(vecs[i].h2);
      end
      segs.push_back(FLUSH);
      run_segs(segs, a0);
      check($sformatf("vec%0d short", i), count_kind(0), vecs[i].n_s);
      check($sformatf("vec%0d long", i), count_kind(1), vecs[i].n_l);
      check($sformatf("vec%0d dbl", i), count_kind(2), vecs[i].n_d);
      check($sformatf("vec%0d busy", i), int'(busy), 0);
      ev_q.delete();
    end

    // Short click: pulse DT+1 cycles after entering WAIT2.
    run_segs('{50, FLUSH}, a0);
    check_events("short click", '{(a0 + 50 + 2 + DT + 1) * 4 + 0});
    check("short click busy", int'(busy), 0);

    // Long hold: pulse LT+1 cycles after entering PRESS1, silent release.
    run_segs('{300, FLUSH}, a0);
    check_events("long hold", '{(a0 + 2 + LT + 1) * 4 + 1});

    // Double click: pulse two cycles after the second release edge.
    run_segs('{30, 40, 30, FLUSH}, a0);
    check_events("double click", '{(a0 + 100 + 2) * 4 + 2});

    // Reset in the middle of PRESS1 with the key still held.
    key_in = 1'b0;
    step(50);
    check("pre-reset busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("async reset busy", int'(busy), 0);
    step(5);
    rst = 1'b0;
    step(1);
    check_idle("after reset held");
    step(LT + 50);
    check("held after reset busy", int'(busy), 0);
    key_in = 1'b1;
    step(FLUSH);
    check_events("held through reset", none);
    run_segs('{30, FLUSH}, a0);
    check_events("click after reset", '{(a0 + 30 + 2 + DT + 1) * 4 + 0});

    // Enable drop while a short press is pending in WAIT2.
    key_in = 1'b0;
    step(30);
    key_in = 1'b1;
    step(2 + DT / 2);
    check("wait2 busy", int'(busy), 1);
    en = 1'b0;
    step(1);
    check("en low busy", int'(busy), 0);
    step(9);
    en = 1'b1;
    step(FLUSH);
    check_events("en drop", none);

    // Hold past LONG_MS for repeat behaviour.
    run_segs('{LT + DT * 5 / 2, FLUSH}, a0);
    e = a0 + 2 + LT + 1;
    b = a0 + LT + DT * 5 / 2;
`ifdef KEY_REPEAT_EN
    exp = '{e * 4 + 1, (e + RT + 1) * 4 + 3, (e + 2 * RT + 2) * 4 + 3};
`else
    exp = '{e * 4 + 1};
`endif
    check_events("repeat hold", exp);
    check("repeat hold busy", int'(busy), 0);
    check("repeat release seen", int'(b < cyc), 1);

    for (int r = 0; r < 4; r++) begin
      segs.delete();
      for (int i = 0; i < 25; i++) begin
        segs.push_back(pick_len(LT + 1));
        segs.push_back(pick_len(DT + 1));
      end
      segs[segs.size() - 1] = FLUSH;
      run_segs(segs, a0);
      model(a0, segs, exp);
      check_events($sformatf("random run %0d", r), exp);
      check($sformatf("random run %0d busy", r), int'(busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
